pipe_adder: RTL and testbench

Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready handshake on both sides. It generalises the single-bit full-adder cell to multi-bit operands. The carry chain is cut into STAGES chunks, one register stage per chunk. It sits between operand producers and any datapath consumer that needs wide add/sub at full clock rate, and reports carry-out and signed overflow.

---
 rtl/pipe_adder_pkg.sv | 12 +
 rtl/add_chunk.sv | 22 ++
 rtl/pipe_adder.sv | 135 +++++++++++++
 tb/tb_pipe_adder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: op encodings and chunk-width helper shared by pipe_adder.
// No ports; holds no WIDTH-dependent state.
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// add_chunk: combinational CW-bit adder slice.
// Ports: a, b, c_in -> s, c_out, c_msb_in (carry into the slice MSB).
module add_chunk
  import pipe_adder_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          c_in,
  output logic [CW-1:0] s,
  output logic          c_out,
  output logic          c_msb_in
);

  always_comb begin
    {c_out, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, c_in};
    // carry into the MSB recovered from the MSB sum bit
    c_msb_in = s[CW-1] ^ a[CW-1] ^ b[CW-1];
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep pipelined add/sub, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready, a, b, cin, sub,
//   out_valid/out_ready, sum, cout, ovf.
// Option: define PIPE_ADDER_SAT_EN to clamp sum on signed overflow.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunk_w(WIDTH, STAGES);

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {WIDTH{1'b1}} >> 1;
  localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;
`endif

  logic [STAGES-1:0] v_q, v_d, ld, en;
  logic [STAGES-1:0] src_v, src_c;
  logic [STAGES-1:0] c_q, c_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [CW-1:0]    ch_s [STAGES];
  logic             ch_cm [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_first
      // subtract folds into add: ~b and inverted borrow-in
      assign a_d[k]   = a;
      assign b_d[k]   = (sub == OP_SUB) ? ~b : b;
      assign src_s[k] = '0;
      assign src_c[k] = (sub == OP_SUB) ? ~cin : cin;
      assign src_v[k] = in_valid;
    end else begin : g_next
      assign a_d[k]   = a_q[k-1];
      assign b_d[k]   = b_q[k-1];
      assign src_s[k] = s_q[k-1];
      assign src_c[k] = c_q[k-1];
      assign src_v[k] = v_q[k-1];
    end

    add_chunk #(.CW(CW)) u_chunk (
      .a        (a_d[k][k*CW +: CW]),
      .b        (b_d[k][k*CW +: CW]),
      .c_in     (src_c[k]),
      .s        (ch_s[k]),
      .c_out    (c_d[k]),
      .c_msb_in (ch_cm[k])
    );
  end

  // stage k may load if it or any stage after it has room
  always_comb begin
    logic f;
    f = out_ready;
    ld = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      f = f | ~v_q[k];
      ld[k] = f;
    end
  end

  assign in_ready = ld[0];

  always_comb begin
    en = '0;
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      en[k]  = ld[k] & src_v[k];
      v_d[k] = ld[k] ? src_v[k] : v_q[k];
      s_d[k] = src_s[k];
      s_d[k][k*CW +: CW] = ch_s[k];
    end
    ovf_d = ch_cm[STAGES-1] ^ c_d[STAGES-1];
`ifdef PIPE_ADDER_SAT_EN
    if (ovf_d) begin
      s_d[STAGES-1] = c_d[STAGES-1] ? SAT_NEG : SAT_POS;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (en[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: random + directed bench for pipe_adder with a
// scoreboard model computed from signed/unsigned integer arithmetic.
module tb_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  logic v1 = 1'b0, r1, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic sb1 = 1'b0, ov1, or1 = 1'b1, s1, co1, of1;

  pipe_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1),
    .a(a1), .b(b1), .cin(c1), .sub(sb1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1), .ovf(of1)
  );

  int tests = 0;
  int fails = 0;
  int n_del = 0;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t q[$];

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t   r;
    longint t, mx, mn;
    mx = (longint'(1) <<< (W-1)) - 1;
    mn = -(longint'(1) <<< (W-1));
    if (!sb) begin
      t   = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      r.c = (longint'(x) + longint'(y) + longint'(ci)) >= (longint'(1) <<< W);
    end else begin
      t   = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
      r.c = longint'(x) >= (longint'(y) + longint'(ci));
    end
    r.o = (t > mx) || (t < mn);
    r.s = t[W-1:0];
    if (SAT && t > mx) r.s = mx[W-1:0];
    if (SAT && t < mn) r.s = mn[W-1:0];
    return r;
  endfunction

  res_t hv;
  bit   held = 1'b0;

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (q.size() < S) || out_ready);
      if (held && out_valid) begin
        check("stall_hold", {sum, cout, ovf}, hv);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          check("ovf", ovf, e.o);
          n_del++;
        end
      end
      held = out_valid && !out_ready;
      hv = {sum, cout, ovf};
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic xc,
                          input logic xs, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    #1;
    check({nm, "_rdy"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, "_lat"}, lat, S);
    check({nm, "_sum"}, sum, es);
    check({nm, "_cout"}, cout, ec);
    check({nm, "_ovf"}, ovf, eo);
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, cyc, cnt, d0;
    bit dropped;

    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    tick();

    // 1-bit, 1-stage adder: full-adder truth table
    for (int k = 0; k < 8; k++) begin
      {a1, b1, c1} = 3'(k);
      v1 = 1'b1;
      #1;
      check("w1_ready", r1, 1);
      tick();
      v1 = 1'b0;
      check("w1_valid", ov1, 1);
      check("w1_sum", {co1, s1}, int'(a1) + int'(b1) + int'(c1));
    end
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check("w1_111_sum", s1, 1);
    check("w1_111_cout", co1, 1);
    tick();

    directed("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0,
             16'h0000, 1'b1, 1'b0);
    directed("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
             SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    directed("5_m_7", 16'h0005, 16'h0007, 1'b0, 1'b1,
             16'hFFFE, 1'b0, 1'b0);
    directed("7_m_5_b", 16'h0007, 16'h0005, 1'b1, 1'b1,
             16'h0001, 1'b1, 1'b0);
    directed("8000_p8000", 16'h8000, 16'h8000, 1'b0, 1'b0,
             SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);
    tick();

    // back-to-back with a 6-cycle output stall
    d0 = n_del;
    i = 0; cyc = 0; dropped = 1'b0;
    while (i < 10 && cyc < 100) begin
      a = W'(i); b = W'(i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      out_ready = !(cyc >= 3 && cyc < 9);
      #1;
      if (!in_ready && !dropped) begin
        dropped = 1'b1;
        check("b2b_occ_at_drop", q.size(), S);
      end
      if (in_ready) i++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("b2b_ready_dropped", dropped, 1);
    cnt = 0;
    while (q.size() != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("b2b_drained", q.size(), 0);
    check("b2b_delivered", n_del - d0, 10);

    // random traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      a = pick(); b = pick();
      cin = 1'($urandom); sub = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (q.size() != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    check("rand_drained", q.size(), 0);

    // reset with beats in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = W'(k + 100); b = W'(k); sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_fly_valid", out_valid, 0);
    check("rst_fly_sum", sum, 0);
    check("rst_fly_cout", cout, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", in_ready, 1);
    check("rst_rel_valid", out_valid, 0);
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("rst_no_stale", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
